mips_prog_mem: RTL and testbench

MIPS_PROG_MEM -- requirements
Module: mips_prog_mem

---
 rtl/mips_prog_mem_if.sv | 30 +++
 rtl/mips_prog_mem.sv | 112 +++++++++++
 tb/tb_mips_prog_mem.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_prog_mem_if.sv
// CPU bus and byte-loader bundle for mips_prog_mem.
// master = CPU/loader side, slave = memory side.
interface mips_prog_mem_if;
  logic        memread;
  logic        memwrite;
  logic [7:0]  adr;
  logic [7:0]  writedata;
  logic [7:0]  memdata;
  logic        cpu_reset;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output memread, memwrite, adr, writedata,
    output ld_valid, ld_data, ld_last,
    input  memdata, cpu_reset, ld_ready,
    input  rd_count, wr_count
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    input  ld_valid, ld_data, ld_last,
    output memdata, cpu_reset, ld_ready,
    output rd_count, wr_count
  );
endinterface

// File: rtl/mips_prog_mem.sv
// 256x8 program memory: loads an image byte-by-byte while holding
// the CPU in reset, then serves CPU reads/writes until reset.
module mips_prog_mem #(
  parameter int LOAD_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [7:0]  adr,
  input  logic [7:0]  writedata,
  output logic [7:0]  memdata,
  output logic        cpu_reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);
  typedef enum logic {LOAD, RUN} state_e;

  localparam logic [7:0] LAST_PTR = 8'(LOAD_LEN - 1);

  mips_prog_mem_if bus ();

  assign bus.memread   = memread;
  assign bus.memwrite  = memwrite;
  assign bus.adr       = adr;
  assign bus.writedata = writedata;
  assign bus.ld_valid  = ld_valid;
  assign bus.ld_data   = ld_data;
  assign bus.ld_last   = ld_last;

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  memdata_q, memdata_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] wr_q, wr_d;
  logic [7:0]  mem_q [256];
  logic        we;
  logic [7:0]  waddr;
  logic [7:0]  wdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    memdata_d = memdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    we        = 1'b0;
    waddr     = ptr_q;
    wdata     = bus.ld_data;
    unique case (state_q)
      LOAD: begin
        if (bus.ld_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + 8'd1;
          if (bus.ld_last || ptr_q == LAST_PTR)
            state_d = RUN;
        end
      end
      RUN: begin
        // read samples the array before this edge's write lands
        if (bus.memread) begin
          memdata_d = mem_q[bus.adr];
          if (rd_q != 16'hFFFF) rd_d = rd_q + 16'd1;
        end
        if (bus.memwrite) begin
          we    = 1'b1;
          waddr = bus.adr;
          wdata = bus.writedata;
          if (wr_q != 16'hFFFF) wr_d = wr_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      ptr_q     <= '0;
      memdata_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      memdata_q <= memdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  // contents survive reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (reset && we) mem_q[waddr] <= wdata;
  end

  assign bus.memdata   = memdata_q;
  assign bus.cpu_reset = (state_q == LOAD);
  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.rd_count  = rd_q;
  assign bus.wr_count  = wr_q;

  assign memdata   = bus.memdata;
  assign cpu_reset = bus.cpu_reset;
  assign ld_ready  = bus.ld_ready;
  assign rd_count  = bus.rd_count;
  assign wr_count  = bus.wr_count;
endmodule

// File: tb/tb_mips_prog_mem.sv
// Directed + randomized bench for mips_prog_mem against a
// behavioural model; second instance exercises LOAD_LEN=4.
module tb_mips_prog_mem;
  logic clk;
  logic rst_n;

  mips_prog_mem_if bi ();
  mips_prog_mem_if b4 ();

  mips_prog_mem dut (
    .clk(clk), .reset(rst_n),
    .memread(bi.memread), .memwrite(bi.memwrite),
    .adr(bi.adr), .writedata(bi.writedata),
    .memdata(bi.memdata), .cpu_reset(bi.cpu_reset),
    .ld_valid(bi.ld_valid), .ld_data(bi.ld_data),
    .ld_last(bi.ld_last), .ld_ready(bi.ld_ready),
    .rd_count(bi.rd_count), .wr_count(bi.wr_count)
  );

  mips_prog_mem #(.LOAD_LEN(4)) dut4 (
    .clk(clk), .reset(rst_n),
    .memread(b4.memread), .memwrite(b4.memwrite),
    .adr(b4.adr), .writedata(b4.writedata),
    .memdata(b4.memdata), .cpu_reset(b4.cpu_reset),
    .ld_valid(b4.ld_valid), .ld_data(b4.ld_data),
    .ld_last(b4.ld_last), .ld_ready(b4.ld_ready),
    .rd_count(b4.rd_count), .wr_count(b4.wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  // reference model of the default-size instance
  bit         m_run;
  int         m_ptr;
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_data;
  bit         m_dknown;
  int         m_rd;
  int         m_wr;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_run    = 1'b0;
    m_ptr    = 0;
    m_data   = 8'h00;
    m_dknown = 1'b1;
    m_rd     = 0;
    m_wr     = 0;
  endtask

  task automatic check_main(string tag);
    check({tag, ".ld_ready"}, 16'(bi.ld_ready), 16'(!m_run));
    check({tag, ".cpu_reset"}, 16'(bi.cpu_reset), 16'(!m_run));
    if (m_dknown) check({tag, ".memdata"}, 16'(bi.memdata), 16'(m_data));
    check({tag, ".rd_count"}, bi.rd_count, 16'(m_rd));
    check({tag, ".wr_count"}, bi.wr_count, 16'(m_wr));
  endtask

  // advance the model by one edge from the current inputs, then clock
  task automatic tick(bit chk, string tag);
    if (rst_n) begin
      if (!m_run) begin
        if (bi.ld_valid) begin
          m_mem[m_ptr]   = bi.ld_data;
          m_known[m_ptr] = 1'b1;
          if (bi.ld_last || m_ptr == 255) m_run = 1'b1;
          m_ptr = (m_ptr + 1) % 256;
        end
      end else begin
        if (bi.memread) begin
          m_data   = m_mem[bi.adr];
          m_dknown = m_known[bi.adr];
          if (m_rd < 65535) m_rd++;
        end
        if (bi.memwrite) begin
          m_mem[bi.adr]   = bi.writedata;
          m_known[bi.adr] = 1'b1;
          if (m_wr < 65535) m_wr++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (chk) check_main(tag);
  endtask

  task automatic cpu(bit rd, bit wr, logic [7:0] a, logic [7:0] d,
                     string tag);
    bi.memread   = rd;
    bi.memwrite  = wr;
    bi.adr       = a;
    bi.writedata = d;
    tick(1'b1, tag);
    bi.memread  = 1'b0;
    bi.memwrite = 1'b0;
  endtask

  task automatic ld(bit v, logic [7:0] d, bit last, string tag);
    bi.ld_valid = v;
    bi.ld_data  = d;
    bi.ld_last  = last;
    tick(1'b1, tag);
    bi.ld_valid = 1'b0;
    bi.ld_last  = 1'b0;
  endtask

  // assert reset between edges, check async effect, release next cycle
  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_main(tag);
    check({tag, ".b4_ready"}, 16'(b4.ld_ready), 16'd1);
    check({tag, ".b4_cpurst"}, 16'(b4.cpu_reset), 16'd1);
    check({tag, ".b4_memdata"}, 16'(b4.memdata), 16'd0);
    check({tag, ".b4_rd"}, b4.rd_count, 16'd0);
    check({tag, ".b4_wr"}, b4.wr_count, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp4 [6];
    logic [7:0] img [$];
    int n;

    rst_n = 1'b0;
    bi.memread = 0; bi.memwrite = 0; bi.adr = 0; bi.writedata = 0;
    bi.ld_valid = 0; bi.ld_data = 0; bi.ld_last = 0;
    b4.memread = 0; b4.memwrite = 0; b4.adr = 0; b4.writedata = 0;
    b4.ld_valid = 0; b4.ld_data = 0; b4.ld_last = 0;
    m_reset();
    #1;
    check_main("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LOAD_LEN=4: seed addresses 4,5 in RUN, then reset and overfeed
    b4.ld_valid = 1; b4.ld_data = 8'h00; b4.ld_last = 1;
    tick(1'b0, "");
    b4.ld_valid = 0; b4.ld_last = 0;
    check("b4_seed_run", 16'(b4.ld_ready), 16'd0);
    b4.memwrite = 1; b4.adr = 8'h04; b4.writedata = 8'h5B;
    tick(1'b0, "");
    b4.adr = 8'h05; b4.writedata = 8'h5C;
    tick(1'b0, "");
    b4.memwrite = 0;
    check("b4_seed_wr", b4.wr_count, 16'd2);
    do_reset("rst_b4");

    b4.memread = 1; b4.memwrite = 1; b4.adr = 8'h05;
    b4.writedata = 8'hCC; b4.ld_valid = 1; b4.ld_last = 0;
    for (int i = 0; i < 6; i++) begin
      b4.ld_data = 8'(8'hA1 + i);
      tick(1'b0, "");
      if (i < 3) begin
        check("b4_load_ready", 16'(b4.ld_ready), 16'd1);
        check("b4_load_memdata", 16'(b4.memdata), 16'd0);
        check("b4_load_rd", b4.rd_count, 16'd0);
        check("b4_load_wr", b4.wr_count, 16'd0);
      end else if (i == 3) begin
        check("b4_run_ready", 16'(b4.ld_ready), 16'd0);
        check("b4_run_cpurst", 16'(b4.cpu_reset), 16'd0);
        check("b4_run_rd", b4.rd_count, 16'd0);
        check("b4_run_wr", b4.wr_count, 16'd0);
        b4.memread = 0; b4.memwrite = 0;
      end
    end
    b4.ld_valid = 0;
    exp4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h5B, 8'h5C};
    for (int a = 0; a < 6; a++) begin
      b4.memread = 1; b4.adr = 8'(a);
      tick(1'b0, "");
      check($sformatf("b4_rd%0d", a), 16'(b4.memdata), 16'(exp4[a]));
    end
    b4.memread = 0;
    check("b4_final_rd", b4.rd_count, 16'd6);
    check("b4_final_wr", b4.wr_count, 16'd0);

    // boot image with ld_last on the 4th byte
    do_reset("rst_main");
    ld(1, 8'h44, 0, "boot0");
    ld(1, 8'h00, 0, "boot1");
    ld(1, 8'h02, 0, "boot2");
    ld(1, 8'h80, 1, "boot3");
    check("boot_ready", 16'(bi.ld_ready), 16'd0);
    check("boot_cpurst", 16'(bi.cpu_reset), 16'd0);
    cpu(1, 0, 8'h00, 8'h00, "rd00");
    check("rd00_lit", 16'(bi.memdata), 16'h44);
    cpu(1, 0, 8'h03, 8'h00, "rd03");
    check("rd03_lit", 16'(bi.memdata), 16'h80);
    cpu(0, 0, 8'h00, 8'h00, "hold");
    check("hold_lit", 16'(bi.memdata), 16'h80);

    cpu(0, 1, 8'h10, 8'hA0, "wr10");
    cpu(1, 0, 8'h10, 8'h00, "rd10");
    check("rd10_lit", 16'(bi.memdata), 16'hA0);
    cpu(1, 1, 8'h10, 8'h5A, "rw10");
    check("rw10_old", 16'(bi.memdata), 16'hA0);
    cpu(1, 0, 8'h10, 8'h00, "rd10b");
    check("rd10b_new", 16'(bi.memdata), 16'h5A);

    for (int a = 16; a < 32; a++)
      cpu(0, 1, 8'(a), 8'($urandom), "fill");
    for (int i = 0; i < 300; i++)
      cpu(1'($urandom), 1'($urandom), 8'(16 + $urandom_range(15)),
          8'($urandom), "rand_run");

    // drive both counters past saturation
    bi.memread = 1; bi.memwrite = 1; bi.adr = 8'h11;
    for (int i = 0; i < 65540; i++) begin
      bi.writedata = 8'(i);
      tick(1'b0, "");
    end
    bi.memread = 0; bi.memwrite = 0;
    check_main("sat");
    check("sat_rd", bi.rd_count, 16'hFFFF);
    check("sat_wr", bi.wr_count, 16'hFFFF);

    // reset mid-RUN keeps the array
    cpu(0, 1, 8'h20, 8'h77, "wr20");
    do_reset("rst_run");
    ld(1, 8'h99, 1, "reload");
    cpu(1, 0, 8'h20, 8'h00, "rd20");
    check("rd20_lit", 16'(bi.memdata), 16'h77);
    cpu(1, 0, 8'h00, 8'h00, "rd00b");
    check("rd00b_lit", 16'(bi.memdata), 16'h99);

    // loader gaps
    do_reset("rst_gap");
    ld(1, 8'h11, 0, "gap0");
    ld(0, 8'hEE, 0, "gap1");
    ld(1, 8'h22, 0, "gap2");
    ld(0, 8'hEE, 0, "gap3");
    ld(1, 8'h33, 1, "gap4");
    cpu(1, 0, 8'h00, 8'h00, "gap_rd0");
    check("gap_rd0_lit", 16'(bi.memdata), 16'h11);
    cpu(1, 0, 8'h01, 8'h00, "gap_rd1");
    check("gap_rd1_lit", 16'(bi.memdata), 16'h22);
    cpu(1, 0, 8'h02, 8'h00, "gap_rd2");
    check("gap_rd2_lit", 16'(bi.memdata), 16'h33);

    // random image with random loader gaps
    do_reset("rst_rand");
    n = 1 + $urandom_range(19);
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(2) == 0)
        ld(0, 8'($urandom), 1'($urandom), "rgap");
      ld(1, img[i], i == n - 1, "rload");
    end
    for (int a = 0; a < n; a++) begin
      cpu(1, 0, 8'(a), 8'h00, "rimg");
      check($sformatf("rimg%0d", a), 16'(bi.memdata), 16'(img[a]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
